// File: rtl/m_stage_dbus_master.sv
// Memory-stage data-bus master: decodes M-stage load/store requests and runs a
// req/ack transaction with timeout, stalling the pipeline until completion.
module m_stage_dbus_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_memse,
  input  logic        M_memre,
  input  logic [31:0] M_result,
  input  logic [31:0] M_rt,
  input  logic [1:0]  M_memsize,
  input  logic        M_ldsign,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  output logic        mem_stall,
  output logic [31:0] M_ldata,
  output logic        ld_valid,
  output logic        mem_exc,
  output logic        bus_err
);

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic             load_q, load_d;

  logic        bus_req_d, bus_we_d, ld_valid_d, mem_exc_d, bus_err_d;
  logic [31:0] bus_addr_d, bus_wdata_d, ldata_d;
  logic [3:0]  bus_byteen_d;

  logic        req_c, misal_c;
  logic [3:0]  byteen_c;
  logic [31:0] wdata_c, ext_c;
  logic [7:0]  lane_b_c;
  logic [15:0] lane_h_c;

  // Request decode; reserved size 3 behaves as a word access
  always_comb begin
    req_c    = M_memse | M_memre;
    misal_c  = 1'b0;
    byteen_c = 4'b1111;
    wdata_c  = M_rt;
    case (M_memsize)
      SZ_HALF: begin
        misal_c  = M_result[0];
        byteen_c = M_result[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{M_rt[15:0]}};
      end
      SZ_BYTE: begin
        byteen_c = 4'(4'b0001 << M_result[1:0]);
        wdata_c  = {4{M_rt[7:0]}};
      end
      default: misal_c = (M_result[1:0] != 2'b00);
    endcase
  end

  // Load lane extraction and extension using the latched access attributes
  always_comb begin
    lane_b_c = bus_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h_c = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      SZ_HALF: ext_c = {{16{sign_q & lane_h_c[15]}}, lane_h_c};
      SZ_BYTE: ext_c = {{24{sign_q & lane_b_c[7]}}, lane_b_c};
      default: ext_c = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    sign_d       = sign_q;
    load_d       = load_q;
    bus_req_d    = bus_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_byteen_d = bus_byteen;
    bus_wdata_d  = bus_wdata;
    ldata_d      = M_ldata;
    ld_valid_d   = 1'b0;
    mem_exc_d    = 1'b0;
    bus_err_d    = 1'b0;
    mem_stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (misal_c) begin
            mem_exc_d = 1'b1;
          end else begin
            mem_stall    = 1'b1;
            state_d      = REQ;
            addr_lo_d    = M_result[1:0];
            size_d       = M_memsize;
            sign_d       = M_ldsign;
            load_d       = ~M_memse;
            bus_req_d    = 1'b1;
            bus_we_d     = M_memse;
            bus_addr_d   = {M_result[31:2], 2'b00};
            bus_byteen_d = byteen_c;
            bus_wdata_d  = wdata_c;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = DONE;
          if (load_q) begin
            ldata_d    = ext_c;
            ld_valid_d = 1'b1;
          end
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          // Abort: the counter reaching TIMEOUT bounds the request to TIMEOUT cycles
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
          ldata_d   = 32'h0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= 2'b00;
      size_q     <= SZ_WORD;
      sign_q     <= 1'b0;
      load_q     <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_byteen <= 4'h0;
      bus_wdata  <= 32'h0;
      M_ldata    <= 32'h0;
      ld_valid   <= 1'b0;
      mem_exc    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lo_q  <= addr_lo_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      load_q     <= load_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_byteen <= bus_byteen_d;
      bus_wdata  <= bus_wdata_d;
      M_ldata    <= ldata_d;
      ld_valid   <= ld_valid_d;
      mem_exc    <= mem_exc_d;
      bus_err    <= bus_err_d;
    end
  end

endmodule

// File: doc/m_stage_dbus_master.md
Name: m_stage_dbus_master

Overview:
- Memory-stage data-bus master for the 5-stage pipeline.
- Consumes the memory-request fields delivered by the E→M pipeline register: address in M_result, store data in M_rt, and the store/load enables.
- Runs a req/ack handshake with the data-memory responder and holds the pipeline via mem_stall until the access completes.
- Returns lane-aligned, extended load data to the W-stage path.

Parameters:
- TIMEOUT, 255: max cycles in REQ without ack before aborting with bus_err.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- M_memse  input  1  store request this cycle.
- M_memre  input  1  load request this cycle.
- M_result  input  32  byte address.
- M_rt  input  32  store data.
- M_memsize  input  2  access size: 0 word, 1 half, 2 byte, 3 reserved (treated as word).
- M_ldsign  input  1  load sign-extend when 1, zero-extend when 0.
- bus_ack  input  1  responder acknowledge, one-cycle pulse.
- bus_rdata  input  32  read word, valid when bus_ack=1.
- bus_req  output  1  request, registered.
- bus_we  output  1  write strobe, registered.
- bus_addr  output  32  word address {addr[31:2],2'b00}, registered.
- bus_byteen  output  4  byte-lane enables, registered.
- bus_wdata  output  32  lane-replicated store data, registered.
- mem_stall  output  1  freeze F/D/E/M registers.
- M_ldata  output  32  extended load result.
- ld_valid  output  1  M_ldata is fresh this cycle.
- mem_exc  output  1  misaligned access pulse.
- bus_err  output  1  timeout pulse.

Behaviour:
- Reset is synchronous and active-high; clock is clk. After the reset edge:
  - state=IDLE.
  - bus_req, bus_we, bus_byteen, bus_wdata, bus_addr, M_ldata, ld_valid, mem_exc, bus_err all = 0.
  - Timeout counter = 0.
- Reset mid-transaction aborts: bus_req drops at the reset edge, and a later bus_ack is ignored while in IDLE.
- Access decode:
  - Request present when M_memse|M_memre. If both are set, the access is a store.
  - Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001<<addr[1:0].
- Store data:
  - word: M_rt.
  - half: {2{M_rt[15:0]}}.
  - byte: {4{M_rt[7:0]}}.
- FSM IDLE:
  - Aligned request: latch addr, size, sign and we; load bus_* registers; go REQ. mem_stall=1, combinational in this cycle.
  - Misaligned request: no bus access, mem_exc=1 for the next cycle, mem_stall=0, stay IDLE.
  - No request: mem_stall=0.
- FSM REQ:
  - bus_req=1, mem_stall=1, counter increments each cycle.
  - bus_ack=1 at an edge: drop bus_req and bus_we. For a load, capture the extended lane into M_ldata. Go DONE.
  - counter==TIMEOUT without ack: drop bus_req, bus_err=1 next cycle, M_ldata=0, go DONE.
- FSM DONE:
  - mem_stall=0. ld_valid=1 only if the access was a load.
  - Pipeline advances at this edge. Go IDLE and clear the counter.
  - A new request is not accepted in DONE; it is evaluated in IDLE on the next cycle.
- Load extract:
  - Byte lane = rdata[8*a+7:8*a], where a = addr[1:0].
  - Half lane = addr[1] ? rdata[31:16] : rdata[15:0].
  - Extend to 32 bits per M_ldsign.
- Latency: with ack in the first REQ cycle, an access occupies 3 cycles (IDLE-detect, REQ, DONE), and mem_stall is high for 2 of them.
- M_ldata holds its value until the next completed load or reset.
- bus_ack outside REQ is ignored.

Test Plan:
- Word load: M_memre=1, M_result=0x1004, bus_ack on the first REQ cycle, bus_rdata=0xDEADBEEF → bus_addr=0x1004, byteen=1111, mem_stall high 2 cycles, DONE with ld_valid=1 and M_ldata=0xDEADBEEF.
- Signed byte load: addr=0x2003, size=2, sign=1, rdata=0x80FF7F01 → byteen=1000, M_ldata=0xFFFFFF80. The same access with sign=0 → 0x00000080.
- Half store: addr=0x3002, M_rt=0x1234ABCD, size=1 → bus_we=1, byteen=1100, wdata=0xABCDABCD, ld_valid=0 in DONE.
- Misaligned: word load at 0x4001 → bus_req stays 0, mem_exc pulses 1 cycle, mem_stall=0.
- Timeout: TIMEOUT=4, no ack → bus_req high 4 cycles then 0, bus_err pulses 1 cycle, M_ldata=0, mem_stall released in DONE.
- Reset in REQ: assert reset on the 2nd REQ cycle, then pulse bus_ack → all outputs 0, state IDLE, ld_valid stays 0.
